// File: rtl/nn_inference_sequencer.sv
// nn_inference_sequencer: runs one inference at a time on an ap_ctrl_hs core.
// Optional ARGMAX_EN adds res_class, the index of the largest signed lane value.
module nn_inference_sequencer #(
    parameter int DATA_W     = 16,
    parameter int N_OUT      = 16,
    parameter int N_IN_BEATS = 1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [DATA_W-1:0]       s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic                    core_ap_start,
    input  logic                    core_ap_ready,
    input  logic                    core_ap_done,
    input  logic                    core_ap_idle,
    output logic [DATA_W-1:0]       core_in_tdata,
    output logic                    core_in_tvalid,
    input  logic                    core_in_tready,
    input  logic [N_OUT*DATA_W-1:0] core_out_tdata,
    input  logic [N_OUT-1:0]        core_out_tvalid,
    output logic [N_OUT-1:0]        core_out_tready,
    output logic [N_OUT*DATA_W-1:0] res_tdata,
    output logic                    res_tvalid,
    input  logic                    res_tready,
    output logic                    busy,
`ifdef ARGMAX_EN
    output logic [$clog2(N_OUT)-1:0] res_class,
`endif
    output logic [15:0]             infer_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FEED, S_COLLECT, S_RESULT
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              beat_q, beat_d;
    logic [N_OUT-1:0]        cap_q, cap_d;
    logic                    done_q, done_d;
    logic                    ack_q, ack_d;
    logic [N_OUT*DATA_W-1:0] res_q, res_d;
    logic [15:0]             cnt_q, cnt_d;

    // State and flag registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            cap_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cap_q   <= cap_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, flag updates and output decode
    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        cap_d           = cap_q;
        done_d          = done_q;
        ack_d           = ack_q;
        res_d           = res_q;
        cnt_d           = cnt_q;
        s_tready        = 1'b0;
        core_in_tdata   = '0;
        core_in_tvalid  = 1'b0;
        core_out_tready = '0;
        res_tvalid      = 1'b0;
        busy            = (state_q != S_IDLE);
        // start stays up until the core acknowledges it once
        core_ap_start   = (state_q != S_IDLE) && !ack_q;
        if (core_ap_start && core_ap_ready)
            ack_d = 1'b1;
        if ((state_q == S_FEED || state_q == S_COLLECT) && core_ap_done)
            done_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                beat_d = '0;
                cap_d  = '0;
                done_d = 1'b0;
                ack_d  = 1'b0;
                if (s_tvalid && core_ap_idle)
                    state_d = S_START;
            end
            S_START: state_d = S_FEED;
            S_FEED: begin
                core_in_tdata  = s_tdata;
                core_in_tvalid = s_tvalid;
                s_tready       = core_in_tready;
                if (s_tvalid && core_in_tready) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == 8'(N_IN_BEATS - 1))
                        state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                core_out_tready = ~cap_q;
                for (int i = 0; i < N_OUT; i++) begin
                    if (core_out_tvalid[i] && !cap_q[i]) begin
                        res_d[i*DATA_W +: DATA_W] =
                            core_out_tdata[i*DATA_W +: DATA_W];
                        cap_d[i] = 1'b1;
                    end
                end
                if ((&cap_q) && done_q)
                    state_d = S_RESULT;
            end
            S_RESULT: begin
                res_tvalid = 1'b1;
                if (res_tready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign res_tdata = res_q;
    assign infer_cnt = cnt_q;

`ifdef ARGMAX_EN
    localparam int CW = $clog2(N_OUT);

    logic [CW-1:0]            cls_q, best_idx;
    logic signed [DATA_W-1:0] best_val;

    // Largest signed lane; strict compare keeps the lowest index on ties
    always_comb begin
        best_idx = '0;
        best_val = res_q[0 +: DATA_W];
        for (int i = 1; i < N_OUT; i++) begin
            if ($signed(res_q[i*DATA_W +: DATA_W]) > best_val) begin
                best_val = res_q[i*DATA_W +: DATA_W];
                best_idx = i[CW-1:0];
            end
        end
    end

    // Class index captured as the result is presented
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            cls_q <= '0;
        else if (state_q == S_COLLECT && state_d == S_RESULT)
            cls_q <= best_idx;
    end

    assign res_class = cls_q;
`endif

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// tb_nn_inference_sequencer: directed vectors for nn_inference_sequencer.
// Define ARGMAX_EN for both files to exercise res_class.
module tb_nn_inference_sequencer;

    localparam int DW = 16;
    localparam int NO = 16;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid;
    logic            s_tready;
    logic            core_ap_start;
    logic            core_ap_ready;
    logic            core_ap_done;
    logic            core_ap_idle;
    logic [DW-1:0]   core_in_tdata;
    logic            core_in_tvalid;
    logic            core_in_tready;
    logic [NO*DW-1:0] core_out_tdata;
    logic [NO-1:0]   core_out_tvalid;
    logic [NO-1:0]   core_out_tready;
    logic [NO*DW-1:0] res_tdata;
    logic            res_tvalid;
    logic            res_tready;
    logic            busy;
    logic [15:0]     infer_cnt;
`ifdef ARGMAX_EN
    logic [3:0]      res_class;
`endif

    nn_inference_sequencer #(
        .DATA_W(DW), .N_OUT(NO), .N_IN_BEATS(1)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready),
        .core_ap_done(core_ap_done), .core_ap_idle(core_ap_idle),
        .core_in_tdata(core_in_tdata), .core_in_tvalid(core_in_tvalid),
        .core_in_tready(core_in_tready),
        .core_out_tdata(core_out_tdata), .core_out_tvalid(core_out_tvalid),
        .core_out_tready(core_out_tready),
        .res_tdata(res_tdata), .res_tvalid(res_tvalid),
        .res_tready(res_tready), .busy(busy),
`ifdef ARGMAX_EN
        .res_class(res_class),
`endif
        .infer_cnt(infer_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [15:0] din;
        logic [15:0] base;
        logic [15:0] stp;
        bit          rev;
        int          bp;
        logic [15:0] e0;
        logic [15:0] e5;
        logic [15:0] e15;
        logic [3:0]  ecls;
    } vec_t;

    vec_t        vecs [4];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = '0;
    logic [15:0] lanes [NO];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_start();
        for (int k = 0; k < 8 && !core_ap_start; k++) step();
        chk("start_seen", 256'(core_ap_start), 256'(1));
    endtask

    // One inference: core model answers the handshake and returns lanes[]
    task automatic run_inf(input logic [15:0] din, input bit rev,
                           input int bp, input logic [15:0] e0,
                           input logic [15:0] e5, input logic [15:0] e15,
                           input logic [3:0] ecls);
        logic [NO*DW-1:0] model;
        logic [NO*DW-1:0] snap;
        int               xfer [NO];
        int               bad;
        for (int i = 0; i < NO; i++) begin
            model[i*DW +: DW] = lanes[i];
            xfer[i] = 0;
        end
        s_tdata  = din;
        s_tvalid = 1'b1;
        core_ap_idle = 1'b1;
        wait_start();
        chk("start_no_sready", 256'(s_tready), 256'(0));
        step();
        chk("feed_start_held", 256'(core_ap_start), 256'(1));
        chk("feed_tdata", 256'(core_in_tdata), 256'(din));
        chk("feed_tvalid", 256'(core_in_tvalid), 256'(1));
        core_in_tready = 1'b1;
        core_ap_ready  = 1'b1;
        #1;
        chk("feed_sready", 256'(s_tready), 256'(1));
        step();
        core_in_tready = 1'b0;
        core_ap_ready  = 1'b0;
        if (bp == 0) s_tvalid = 1'b0;
        chk("collect_start_low", 256'(core_ap_start), 256'(0));
        chk("collect_sready", 256'(s_tready), 256'(0));
        if (!rev) begin
            core_out_tdata  = model;
            core_out_tvalid = '1;
            #1;
            chk("all_lane_tready", 256'(core_out_tready), 256'(16'hFFFF));
            step();
            core_out_tvalid = '0;
            chk("no_res_yet_a", 256'(res_tvalid), 256'(0));
            core_ap_done = 1'b1;
            step();
            core_ap_done = 1'b0;
            chk("no_res_yet_b", 256'(res_tvalid), 256'(0));
            step();
            chk("res_valid", 256'(res_tvalid), 256'(1));
        end else begin
            bad = 0;
            for (int i = NO - 1; i >= 0; i--) begin
                core_out_tvalid[i] = 1'b1;
                core_out_tdata[i*DW +: DW] = lanes[i];
                #1;
                if (core_out_tready[i] !== 1'b1) bad++;
                if (i < NO - 1 && core_out_tready[NO-1] !== 1'b0) bad++;
                for (int j = 0; j < NO; j++)
                    if (core_out_tvalid[j] && core_out_tready[j])
                        xfer[j]++;
                if (i == NO - 2) core_ap_done = 1'b1;
                step();
                core_ap_done = 1'b0;
                if (i == NO - 1)
                    core_out_tdata[i*DW +: DW] = 16'hDEAD;
                else
                    core_out_tvalid[i] = 1'b0;
            end
            chk("rev_tready", 256'(bad), 256'(0));
            bad = 0;
            for (int j = 0; j < NO; j++) if (xfer[j] != 1) bad++;
            chk("lane_xfer_once", 256'(bad), 256'(0));
            chk("rev_no_res_yet", 256'(res_tvalid), 256'(0));
            core_out_tvalid = '0;
            step();
            chk("rev_res_valid", 256'(res_tvalid), 256'(1));
        end
        chk("lane0", 256'(res_tdata[0 +: DW]), 256'(e0));
        chk("lane5", 256'(res_tdata[5*DW +: DW]), 256'(e5));
        chk("lane15", 256'(res_tdata[15*DW +: DW]), 256'(e15));
        chk("res_vec", 256'(res_tdata), 256'(model));
`ifdef ARGMAX_EN
        chk("res_class", 256'(res_class), 256'(ecls));
`else
        if (ecls != 4'd0) ecls = 4'd0;
`endif
        snap = res_tdata;
        bad  = 0;
        for (int k = 0; k < bp; k++) begin
            res_tready = 1'b0;
            step();
            if (res_tdata !== snap || s_tready !== 1'b0 ||
                core_ap_start !== 1'b0 || res_tvalid !== 1'b1)
                bad++;
        end
        if (bp > 0) chk("backpressure", 256'(bad), 256'(0));
        res_tready = 1'b1;
        step();
        res_tready = 1'b0;
        exp_cnt++;
        chk("infer_cnt", 256'(infer_cnt), 256'(exp_cnt));
        chk("idle_after_res", 256'(busy), 256'(0));
        if (bp > 0) begin
            step();
            chk("next_start", 256'(core_ap_start), 256'(1));
        end
    endtask

    initial begin
        vecs[0] = '{16'd9999, 16'd0, 16'd100, 1'b0, 0,
                    16'd0, 16'd500, 16'd1500, 4'd15};
        vecs[1] = '{16'h1234, 16'h0007, 16'h0010, 1'b1, 0,
                    16'h0007, 16'h0057, 16'h00F7, 4'd15};
        vecs[2] = '{16'h00AA, 16'hFFFF, 16'h0000, 1'b0, 20,
                    16'hFFFF, 16'hFFFF, 16'hFFFF, 4'd0};
        vecs[3] = '{16'h0055, 16'h0100, 16'hFFF0, 1'b1, 0,
                    16'h0100, 16'h00B0, 16'h0010, 4'd0};

        ap_rst_n = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0;
        core_ap_ready = 1'b0; core_ap_done = 1'b0; core_ap_idle = 1'b1;
        core_in_tready = 1'b0;
        core_out_tdata = '0; core_out_tvalid = '0;
        res_tready = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_outs", 256'({s_tready, core_ap_start, core_in_tvalid,
                              core_out_tready, res_tvalid}), 256'(0));
        chk("rst_cnt", 256'(infer_cnt), 256'(0));
        ap_rst_n = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NO; i++)
                lanes[i] = vecs[v].base + 16'(i) * vecs[v].stp;
            run_inf(vecs[v].din, vecs[v].rev, vecs[v].bp, vecs[v].e0,
                    vecs[v].e5, vecs[v].e15, vecs[v].ecls);
        end

        s_tvalid = 1'b1;
        core_ap_idle = 1'b0;
        begin
            int bad = 0;
            for (int k = 0; k < 4; k++) begin
                step();
                if (busy !== 1'b0 || core_ap_start !== 1'b0) bad++;
            end
            chk("idle_gating", 256'(bad), 256'(0));
        end
        core_ap_idle = 1'b1;
        step();
        chk("idle_release_start", 256'(core_ap_start), 256'(1));
        for (int i = 0; i < NO; i++) lanes[i] = 16'(i);
        run_inf(16'h0BEE, 1'b0, 0, 16'd0, 16'd5, 16'd15, 4'd15);

`ifdef ARGMAX_EN
        for (int i = 0; i < NO; i++) lanes[i] = 16'd0;
        lanes[0] = 16'hFFFB; lanes[1] = 16'd3;
        lanes[2] = 16'd7;    lanes[3] = 16'd7;
        run_inf(16'h0001, 1'b1, 0, 16'hFFFB, 16'd0, 16'd0, 4'd2);
`endif

        s_tdata = 16'h0777;
        s_tvalid = 1'b1;
        wait_start();
        step();
        core_in_tready = 1'b1;
        core_ap_ready  = 1'b1;
        step();
        core_in_tready = 1'b0;
        core_ap_ready  = 1'b0;
        s_tvalid = 1'b0;
        core_out_tvalid[3] = 1'b1;
        core_out_tdata[3*DW +: DW] = 16'h4242;
        step();
        core_out_tvalid = '0;
        chk("mid_collect_busy", 256'(busy), 256'(1));
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 256'({busy, s_tready, core_ap_start,
                                    core_in_tvalid, core_out_tready,
                                    res_tvalid}), 256'(0));
        chk("async_rst_res", 256'(res_tdata), 256'(0));
        chk("async_rst_cnt", 256'(infer_cnt), 256'(0));
        step();
        ap_rst_n = 1'b1;
        step();
        chk("post_rst_busy", 256'(busy), 256'(0));
        chk("post_rst_cnt", 256'(infer_cnt), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
